// File: rtl/spi_cmd_sequencer_pkg.sv
//------------------------------------------------------------------------------
// spi_cmd_sequencer_pkg
// Shared opcodes, FSM states, header field positions and flag indices.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_cmd_sequencer_pkg;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_READ   = 8'h02;
   localparam logic [7:0] OP_STATUS = 8'h03;

   localparam logic [7:0] MAGIC_DEFAULT = 8'h5A;

   localparam int HDR_OPC_LSB  = 56;
   localparam int HDR_ADDR_LSB = 48;
   localparam int HDR_CNT_LSB  = 40;

   localparam int FLG_OVERRUN = 3;
   localparam int FLG_BAD_OP  = 2;
   localparam int FLG_ABORT   = 1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WR_DATA    = 3'd1,
      S_WR_REQ     = 3'd2,
      S_RD_REQ     = 3'd3,
      S_RD_WAIT    = 3'd4,
      S_ERROR      = 3'd5,
      S_ABORT_WAIT = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_cmd_sequencer_edge.sv
//------------------------------------------------------------------------------
// spi_cmd_sequencer_edge
// Rising-edge detector: one registered copy, single-cycle pulse per edge.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_cmd_sequencer_edge (
   input  logic clk,
   input  logic resetn,
   input  logic sig_in,
   output logic rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (!resetn) r_prev <= 1'b0;
      else         r_prev <= sig_in;
   end

   assign rise = sig_in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
//------------------------------------------------------------------------------
// spi_cmd_sequencer
// Decodes SPI command headers and sequences register reads/writes via req/ack.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_cmd_sequencer
   import spi_cmd_sequencer_pkg::*;
#(
   parameter int         WORD_BITS = 64,
   parameter int         ADDR_BITS = 8,
   parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 cs_n,
   input  logic                 word_valid,
   input  logic [WORD_BITS-1:0] word_in,
   output logic [WORD_BITS-1:0] word_out,
   output logic                 reg_req,
   output logic                 reg_we,
   output logic [ADDR_BITS-1:0] reg_addr,
   output logic [WORD_BITS-1:0] reg_wdata,
   input  logic                 reg_ack,
   input  logic [WORD_BITS-1:0] reg_rdata,
   output logic                 busy,
   output logic [3:0]           flags
);

   state_t               r_state, w_state_nx;
   logic [ADDR_BITS-1:0] r_addr, w_addr_nx;
   logic [7:0]           r_count, w_count_nx;
   logic [WORD_BITS-1:0] r_wdata, w_wdata_nx;
   logic [WORD_BITS-1:0] r_word_out, w_word_out_nx;
   logic                 r_we, w_we_nx;
   logic                 r_req, w_req_nx;
   logic [3:0]           r_flags, w_flags_nx;
   logic [7:0]           r_last_op, w_last_op_nx;
   logic                 w_load_status;
   logic                 w_word_rise, w_cs_rise, w_ev, w_cs_abort;
   logic [7:0]           w_opcode, w_hdr_cnt;

   spi_cmd_sequencer_edge u_word_edge (
      .clk    (clk),
      .resetn (resetn),
      .sig_in (word_valid),
      .rise   (w_word_rise)
   );

   spi_cmd_sequencer_edge u_cs_edge (
      .clk    (clk),
      .resetn (resetn),
      .sig_in (cs_n),
      .rise   (w_cs_rise)
   );

   function automatic logic [WORD_BITS-1:0] status_word(input logic [7:0] op,
                                                        input logic [3:0] flg);
      status_word = {MAGIC, op, 4'b0000, flg, {(WORD_BITS-24){1'b0}}};
   endfunction

   assign w_ev       = w_word_rise & ~cs_n;
   assign w_opcode   = word_in[HDR_OPC_LSB +: 8];
   assign w_hdr_cnt  = word_in[HDR_CNT_LSB +: 8];
   // ABORT_WAIT is already unwinding an abort, so a second edge there is moot.
   assign w_cs_abort = w_cs_rise && (r_state != S_IDLE) && (r_state != S_ABORT_WAIT);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_count    <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_req      <= 1'b0;
         r_flags    <= '0;
         r_last_op  <= '0;
         r_word_out <= status_word(8'h00, 4'b0000);
      end else begin
         r_state    <= w_state_nx;
         r_addr     <= w_addr_nx;
         r_count    <= w_count_nx;
         r_wdata    <= w_wdata_nx;
         r_we       <= w_we_nx;
         r_req      <= w_req_nx;
         r_flags    <= w_flags_nx;
         r_last_op  <= w_last_op_nx;
         r_word_out <= w_word_out_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_addr_nx     = r_addr;
      w_count_nx    = r_count;
      w_wdata_nx    = r_wdata;
      w_we_nx       = r_we;
      w_req_nx      = r_req;
      w_flags_nx    = r_flags;
      w_last_op_nx  = r_last_op;
      w_word_out_nx = r_word_out;
      w_load_status = 1'b0;

      if (w_cs_abort) begin
         w_flags_nx[FLG_ABORT] = 1'b1;
         w_load_status         = 1'b1;
         // A request in flight is never withdrawn; an ack this cycle completes it.
         if (r_req && !reg_ack) begin
            w_state_nx = S_ABORT_WAIT;
         end else begin
            w_state_nx = S_IDLE;
            w_req_nx   = 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ev) begin
                  w_last_op_nx = w_opcode;
                  case (w_opcode)
                     OP_NOP: w_load_status = 1'b1;
                     OP_STATUS: begin
                        w_word_out_nx = status_word(w_opcode, r_flags);
                        w_flags_nx    = '0;
                     end
                     OP_WRITE: begin
                        w_addr_nx  = word_in[HDR_ADDR_LSB +: ADDR_BITS];
                        w_count_nx = (w_hdr_cnt == 8'd0) ? 8'd1 : w_hdr_cnt;
                        w_state_nx = S_WR_DATA;
                     end
                     OP_READ: begin
                        w_addr_nx  = word_in[HDR_ADDR_LSB +: ADDR_BITS];
                        w_count_nx = (w_hdr_cnt == 8'd0) ? 8'd1 : w_hdr_cnt;
                        w_we_nx    = 1'b0;
                        w_req_nx   = 1'b1;
                        w_state_nx = S_RD_REQ;
                     end
                     default: begin
                        w_flags_nx[FLG_BAD_OP] = 1'b1;
                        w_load_status          = 1'b1;
                        w_state_nx             = S_ERROR;
                     end
                  endcase
               end
            end
            S_WR_DATA: begin
               if (w_ev) begin
                  w_wdata_nx = word_in;
                  w_we_nx    = 1'b1;
                  w_req_nx   = 1'b1;
                  w_state_nx = S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (reg_ack) begin
                  w_req_nx   = 1'b0;
                  w_addr_nx  = r_addr + 1'b1;
                  w_count_nx = r_count - 8'd1;
                  w_state_nx = (r_count == 8'd1) ? S_IDLE : S_WR_DATA;
               end
            end
            S_RD_REQ: begin
               if (w_ev) w_flags_nx[FLG_OVERRUN] = 1'b1;
               if (reg_ack) begin
                  w_word_out_nx = reg_rdata;
                  w_req_nx      = 1'b0;
                  w_addr_nx     = r_addr + 1'b1;
                  w_count_nx    = r_count - 8'd1;
                  w_state_nx    = (r_count == 8'd1) ? S_IDLE : S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (w_ev) begin
                  w_req_nx   = 1'b1;
                  w_state_nx = S_RD_REQ;
               end
            end
            S_ABORT_WAIT: begin
               if (reg_ack) begin
                  w_req_nx   = 1'b0;
                  w_state_nx = S_IDLE;
               end
            end
            default: ;
         endcase
      end

      if (w_load_status) w_word_out_nx = status_word(w_last_op_nx, w_flags_nx);
   end

   assign word_out  = r_word_out;
   assign reg_req   = r_req;
   assign reg_we    = r_we;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign busy      = (r_state != S_IDLE);
   assign flags     = r_flags;

endmodule

`default_nettype wire
